// File: rtl/spi_meas_master.sv
// SPI mode-0 master for the measurement core: sends {addr, rw}, then a burst of 24-bit words.
// On reads, SCK stalls low while a finished word has nowhere to go because rx_data is still held.
module spi_meas_master #(
    parameter int unsigned CLK_DIV   = 8,
    parameter int unsigned CS_GAP    = 4,
    parameter int unsigned MAX_WORDS = 4096,
    localparam int unsigned CNT_W    = $clog2(MAX_WORDS + 1)
) (
    input  logic             i_sys_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [6:0]       i_cmd_addr,
    input  logic             i_cmd_rw,
    input  logic [CNT_W-1:0] i_num_words,
    input  logic [23:0]      i_tx_data,
    output logic             o_tx_take,
    output logic [23:0]      o_rx_data,
    output logic             o_rx_valid,
    input  logic             i_rx_ready,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_sck,
    output logic             o_ncs,
    output logic             o_mosi,
    input  logic             i_miso
);

    localparam int unsigned TMR_MAX = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
    localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StCmd,
        StData,
        StStall,
        StTail,
        StDone
    } state_t;

    state_t           r_state;
    logic [TMR_W-1:0] r_tmr;
    logic [4:0]       r_bit;
    logic [CNT_W-1:0] r_word;
    logic [CNT_W-1:0] r_nwords;
    logic [6:0]       r_addr;
    logic             r_rw;
    logic [23:0]      r_tx_shift;
    logic [23:0]      r_rx_shift;
    logic             r_rx_full;
    logic [23:0]      r_rx_data;
    logic             r_rx_valid;
    logic             r_sck;
    logic             r_ncs;
    logic             r_mosi;
    logic             r_busy;
    logic             r_done;
    logic             r_tx_take;

    logic             w_div_end;
    logic             w_gap_end;
    logic             w_last_bit;
    logic             w_last_word;
    logic             w_data_rd;
    logic             w_first_mosi;
    logic             w_rx_xfer;
    logic             w_rx_block;
    logic [CNT_W-1:0] w_nwords;

    assign w_div_end    = (r_tmr == TMR_W'(CLK_DIV - 1));
    assign w_gap_end    = (r_tmr == TMR_W'(CS_GAP - 1));
    assign w_last_bit   = (r_state == StCmd) ? (r_bit == 5'd7) : (r_bit == 5'd23);
    assign w_last_word  = (r_word == r_nwords - 1'b1);
    assign w_data_rd    = (r_state == StData) && r_rw;
    assign w_first_mosi = !r_rw && i_tx_data[23];
    assign w_nwords     = (i_num_words > CNT_W'(MAX_WORDS)) ? CNT_W'(MAX_WORDS) : i_num_words;

    // A completed read word moves to rx_data when the holding register is free or being drained.
    assign w_rx_xfer  = r_rx_full && (!r_rx_valid || i_rx_ready);
    assign w_rx_block = r_rx_full && !w_rx_xfer;

    always_ff @(posedge i_sys_clk) begin
        if (!i_rst_n) begin
            r_state    <= StIdle;
            r_tmr      <= '0;
            r_bit      <= '0;
            r_word     <= '0;
            r_nwords   <= '0;
            r_addr     <= '0;
            r_rw       <= 1'b0;
            r_tx_shift <= '0;
            r_rx_shift <= '0;
            r_rx_full  <= 1'b0;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_sck      <= 1'b0;
            r_ncs      <= 1'b1;
            r_mosi     <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_tx_take  <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_tx_take <= 1'b0;

            if (w_rx_xfer) begin
                r_rx_data  <= r_rx_shift;
                r_rx_valid <= 1'b1;
                r_rx_full  <= 1'b0;
            end else if (r_rx_valid && i_rx_ready) begin
                r_rx_valid <= 1'b0;
            end

            case (r_state)
                StIdle: begin
                    if (i_start) begin
                        r_state  <= StSetup;
                        r_tmr    <= '0;
                        r_ncs    <= 1'b0;
                        r_busy   <= 1'b1;
                        r_addr   <= i_cmd_addr;
                        r_rw     <= i_cmd_rw;
                        r_nwords <= w_nwords;
                    end
                end

                StSetup: begin
                    if (w_gap_end) begin
                        r_state    <= StCmd;
                        r_tmr      <= '0;
                        r_bit      <= '0;
                        r_tx_shift <= {r_addr, r_rw, 16'h0000};
                        r_mosi     <= r_addr[6];
                    end else begin
                        r_tmr <= r_tmr + 1'b1;
                    end
                end

                StCmd, StData: begin
                    if (!w_div_end) begin
                        r_tmr <= r_tmr + 1'b1;
                    end else if (!r_sck) begin
                        r_tmr <= '0;
                        r_sck <= 1'b1;
                        if (w_data_rd) begin
                            r_rx_shift <= {r_rx_shift[22:0], i_miso};
                            if (r_bit == 5'd23) r_rx_full <= 1'b1;
                        end
                    end else begin
                        r_tmr <= '0;
                        r_sck <= 1'b0;
                        if (!w_last_bit) begin
                            r_bit      <= r_bit + 1'b1;
                            r_tx_shift <= r_tx_shift << 1;
                            r_mosi     <= w_data_rd ? 1'b0 : r_tx_shift[22];
                        end else begin
                            r_bit <= '0;
                            if (r_state == StCmd && r_nwords == '0) begin
                                r_state <= StTail;
                                r_mosi  <= 1'b0;
                            end else if (r_state == StCmd) begin
                                r_state <= StData;
                                r_word  <= '0;
                                r_mosi  <= w_first_mosi;
                                if (!r_rw) begin
                                    r_tx_shift <= i_tx_data;
                                    r_tx_take  <= 1'b1;
                                end
                            end else if (w_data_rd && w_rx_block) begin
                                r_state <= StStall;
                            end else if (w_last_word) begin
                                r_state <= StTail;
                                r_mosi  <= 1'b0;
                            end else begin
                                r_word <= r_word + 1'b1;
                                r_mosi <= w_first_mosi;
                                if (!r_rw) begin
                                    r_tx_shift <= i_tx_data;
                                    r_tx_take  <= 1'b1;
                                end
                            end
                        end
                    end
                end

                // SCK parked low; the word count only moves once the finished word is handed off.
                StStall: begin
                    r_tmr <= '0;
                    if (!w_rx_block) begin
                        if (w_last_word) begin
                            r_state <= StTail;
                        end else begin
                            r_state <= StData;
                            r_word  <= r_word + 1'b1;
                        end
                    end
                end

                StTail: begin
                    if (w_gap_end) begin
                        r_state <= StDone;
                        r_ncs   <= 1'b1;
                    end else begin
                        r_tmr <= r_tmr + 1'b1;
                    end
                end

                StDone: begin
                    r_state <= StIdle;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                end

                default: r_state <= StIdle;
            endcase
        end
    end

    assign o_tx_take  = r_tx_take;
    assign o_rx_data  = r_rx_data;
    assign o_rx_valid = r_rx_valid;
    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_sck      = r_sck;
    assign o_ncs      = r_ncs;
    assign o_mosi     = r_mosi;

endmodule
